// File: rtl/mskaes_128bits_round_state.sv
// mskaes_128bits_round_state: masked AES-128 state register with sharewise AddRoundKey,
// sequencing the eleven key additions around an external SB/SR/MC datapath.
module mskaes_128bits_round_state #(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [128*d-1:0] sh_data_in,
  input  logic [128*d-1:0] sh_rk,
  output logic [3:0]       rnd_idx,
  output logic [128*d-1:0] sh_state,
  output logic             dp_start,
  input  logic             dp_done,
  input  logic [128*d-1:0] sh_mc_in,
  input  logic [128*d-1:0] sh_sr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] sh_data_out
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t           state, state_nx;
  logic [3:0]       rnd_nx;
  logic [128*d-1:0] sh_nx;
  logic             start_nx;
  logic             last;
  assign last = rnd_idx == 4'd10;
  // dp_done in the dp_start cycle belongs to no valid datapath pass and is dropped
  always_comb begin
    state_nx = state;
    rnd_nx   = rnd_idx;
    sh_nx    = sh_state;
    start_nx = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        sh_nx    = sh_data_in ^ sh_rk;
        rnd_nx   = 4'd1;
        state_nx = ROUND;
        start_nx = 1'b1;
      end
      ROUND: if (dp_done && !dp_start) begin
        sh_nx    = (last ? sh_sr_in : sh_mc_in) ^ sh_rk;
        rnd_nx   = last ? rnd_idx : rnd_idx + 4'd1;
        state_nx = last ? DONE : ROUND;
        start_nx = !last;
      end
      DONE: if (out_ready) begin
        state_nx = IDLE;
        rnd_nx   = 4'd0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      rnd_idx  <= 4'd0;
      sh_state <= '0;
      dp_start <= 1'b0;
    end else begin
      state    <= state_nx;
      rnd_idx  <= rnd_nx;
      sh_state <= sh_nx;
      dp_start <= start_nx;
    end
  assign in_ready    = state == IDLE;
  assign out_valid   = state == DONE;
  assign sh_data_out = sh_state;
endmodule

// File: tb/tb_mskaes_128bits_round_state.sv
// tb_mskaes_128bits_round_state: randomized scoreboard bench with an AES-128 reference model
// and a masked SB/SR/MC datapath stand-in of programmable latency.
module tb_mskaes_128bits_round_state;
  localparam int D = 3;
  localparam int W = 128 * D;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, dp_start, dp_done, out_valid, out_ready;
  logic [W-1:0] sh_data_in, sh_rk, sh_state, sh_mc_in, sh_sr_in, sh_data_out;
  logic [3:0]   rnd_idx;

  mskaes_128bits_round_state #(.d(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sh_data_in(sh_data_in), .sh_rk(sh_rk), .rnd_idx(rnd_idx), .sh_state(sh_state),
    .dp_start(dp_start), .dp_done(dp_done), .sh_mc_in(sh_mc_in), .sh_sr_in(sh_sr_in),
    .out_valid(out_valid), .out_ready(out_ready), .sh_data_out(sh_data_out)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   sb [256];
  logic [127:0] rk_pl [11];
  logic [W-1:0] rk_sh [11];
  logic [127:0] exp_q [$];
  logic [W-1:0] sr_fed;
  logic         dm_done, spur, coin, masks;
  int           lat, cnt;

  assign dp_done = dm_done | spur;
  always_comb sh_rk = rk_sh[rnd_idx > 4'd10 ? 4'd10 : rnd_idx];

  task automatic chki(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin bad++; $display("FAIL %s: got %0d expected %0d", nm, act, req); end
  endtask
  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, req); end
  endtask
  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin bad++; $display("FAIL %s: got %h expected %h", nm, act, req); end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // AES byte k (first byte k=0) is the k-th byte from the MSB of a 128-bit literal
  function automatic logic [127:0] srsb(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = sb[s[127-8*(4*(((k/4)+(k%4))%4)+(k%4)) -: 8]];
    return o;
  endfunction
  function automatic logic [127:0] mc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8]; a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction
  task automatic kexp(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_pl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk_pl[0];
    for (int r = 1; r < 10; r++) s = mc(srsb(s)) ^ rk_pl[r];
    return srsb(s) ^ rk_pl[10];
  endfunction

  // bus byte i holds literal bits [8i+:8]; share j sits 8j bits into that byte lane
  function automatic logic [W-1:0] share(input logic [127:0] v, input logic rnd);
    logic [W-1:0] o;
    logic [7:0] acc, m;
    for (int i = 0; i < 16; i++) begin
      acc = v[8*i +: 8];
      for (int j = 1; j < D; j++) begin
        m = rnd ? 8'($urandom()) : 8'h00;
        o[8*D*i+8*j +: 8] = m;
        acc ^= m;
      end
      o[8*D*i +: 8] = acc;
    end
    return o;
  endfunction
  function automatic logic [127:0] recomb(input logic [W-1:0] b);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < D; j++) r[8*i +: 8] ^= b[8*D*i+8*j +: 8];
    return r;
  endfunction

  initial begin
    logic [7:0] inv, a;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      a = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = a;
    end
  end

  // masked datapath stand-in: fresh random resharing of SR(SB(x)) and MC(SR(SB(x)))
  initial begin
    logic [127:0] x;
    dm_done = 1'b0; sh_mc_in = '0; sh_sr_in = '0; sr_fed = '0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      dm_done = 1'b0;
      if (!rst_n) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) dm_done = 1'b1;
        end
        if (dp_start) begin
          x = srsb(recomb(sh_state));
          sr_fed = share(x, masks);
          sh_sr_in = sr_fed;
          sh_mc_in = share(mc(x), masks);
          cnt = lat;
          if (coin) dm_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got output %h expected none", recomb(sh_data_out));
      end else begin
        chk128("ciphertext", recomb(sh_data_out), exp_q.pop_front());
        chkw("ct_shares", sh_data_out, sr_fed ^ rk_sh[10]);
      end
    end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic rnd);
    int n = 0;
    while (!in_ready && n < 2000) begin tick(); n++; end
    chki("in_ready_wait", int'(in_ready), 1);
    kexp(key);
    for (int r = 0; r < 11; r++) rk_sh[r] = share(rk_pl[r], rnd);
    sh_data_in = share(pt, rnd);
    in_valid = 1'b1;
    exp_q.push_back(aes_ref(pt));
    t0 = cyc;
    tick();
    in_valid = 1'b0;
    sh_data_in = share({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
  endtask
  task automatic wait_ov(output int c);
    int n = 0;
    while (!out_valid && n < 2000) begin tick(); n++; end
    chki("out_valid_wait", int'(out_valid), 1);
    c = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1;
    logic [W-1:0] snap;
    logic [127:0] pt, key;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; spur = 1'b0; coin = 1'b0; masks = 1'b0;
    lat = 3; sh_data_in = '0;
    for (int r = 0; r < 11; r++) rk_sh[r] = '0;
    repeat (3) tick();
    chki("rst_in_ready", int'(in_ready), 1);
    chki("rst_out_valid", int'(out_valid), 0);
    chki("rst_rnd_idx", int'(rnd_idx), 0);
    chki("rst_dp_start", int'(dp_start), 0);
    chkw("rst_state", sh_state, '0);
    rst_n = 1'b1;
    tick();
    // FIPS vector, zero masks, L=3
    send(PT, KEY, 1'b0);
    chk128("load_state", recomb(sh_state), 128'h00102030405060708090a0b0c0d0e0f0);
    chki("load_dp_start", int'(dp_start), 1);
    chki("load_rnd_idx", int'(rnd_idx), 1);
    tick();
    chki("dp_start_pulse", int'(dp_start), 0);
    wait_ov(c);
    chki("latency_L3", c - t0, 41);
    chk128("fips_ct", recomb(sh_data_out), CT);
    tick();
    chki("idle_after_done", int'(in_ready), 1);
    // spurious dp_done in IDLE
    snap = sh_state;
    spur = 1'b1; tick(); spur = 1'b0; tick();
    chki("spur_idle_rnd", int'(rnd_idx), 0);
    chki("spur_idle_ready", int'(in_ready), 1);
    chkw("spur_idle_state", sh_state, snap);
    // random share splits, fixed then random blocks
    masks = 1'b1;
    send(PT, KEY, 1'b1);
    wait_ov(c);
    chki("latency_masked", c - t0, 41);
    for (int b = 0; b < 4; b++) begin
      lat = $urandom_range(1, 4);
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, key, 1'b1);
      wait_ov(c);
      chki("latency_rand", c - t0, 10 * (lat + 1) + 1);
    end
    // backpressure with ignored in_valid and spurious dp_done in DONE
    tick();
    out_ready = 1'b0; lat = 2;
    send({$urandom(), $urandom(), $urandom(), $urandom()}, KEY, 1'b1);
    wait_ov(c);
    snap = sh_data_out;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      sh_data_in = share({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
      spur = (i % 5 == 0);
      tick();
      chki("bp_out_valid", int'(out_valid), 1);
      chki("bp_in_ready", int'(in_ready), 0);
      chki("bp_rnd_idx", int'(rnd_idx), 10);
      chkw("bp_data", sh_data_out, snap);
    end
    in_valid = 1'b0; spur = 1'b0; out_ready = 1'b1;
    tick();
    chki("bp_release_idle", int'(in_ready), 1);
    chki("bp_release_rnd", int'(rnd_idx), 0);
    // dp_done coincident with dp_start
    coin = 1'b1; lat = 2;
    send({$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    tick();
    chki("coin_rnd_idx", int'(rnd_idx), 1);
    wait_ov(c);
    chki("latency_coin", c - t0, 31);
    coin = 1'b0;
    // reset mid-round
    lat = 3;
    send(PT, KEY, 1'b1);
    c = 0;
    while (rnd_idx != 4'd5 && c < 200) begin tick(); c++; end
    chki("reach_rnd5", int'(rnd_idx), 5);
    #2 rst_n = 1'b0;
    #1;
    chkw("midrst_state", sh_state, '0);
    chki("midrst_rnd", int'(rnd_idx), 0);
    chki("midrst_ready", int'(in_ready), 1);
    chki("midrst_valid", int'(out_valid), 0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(PT, KEY, 1'b1);
    wait_ov(c);
    chki("latency_after_rst", c - t0, 41);
    // back-to-back, L=1
    lat = 1;
    send({$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    wait_ov(c1);
    send({$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    chki("b2b_gap", t0 - c1, 1);
    wait_ov(c);
    chki("latency_b2b", c - t0, 21);
    repeat (3) tick();
    chki("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
